// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
// io_bus_pkg : register offsets, STATUS layout and defaults for io_bus_responder
// Revision   : 1.0
// ============================================================================
package io_bus_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_TX_DATA  = 2'd2;
    localparam logic [1:0] OFF_STATUS   = 2'd3;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 2;
    localparam int ST_COUNT_W   = 5;
    localparam int ST_OVF       = 7;
    localparam int ST_INCHG     = 8;

    // Field order matches the STATUS bit positions, LSB last.
    typedef struct packed {
        logic                  in_changed;
        logic                  overflow;
        logic [ST_COUNT_W-1:0] count;
        logic                  full;
        logic                  empty;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        return {23'b0, s};
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_tx_fifo.sv
`default_nettype none
// ============================================================================
// io_tx_fifo : circular transmit FIFO, one push and one pop per cycle
// Revision   : 1.0
// ============================================================================
module io_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_bus_responder.sv
`default_nettype none
// ============================================================================
// io_bus_responder : 16-byte MMIO window with PortOut, synchronized PortIn and TX FIFO
// Revision         : 1.0
// ============================================================================
module io_bus_responder
    import io_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      port_out_q, port_out_d;
    logic [7:0]       s1_q, sync_q, prev_q;
    logic             ovf_q, ovf_d;
    logic             inchg_q, inchg_d;

    logic [1:0]       off;
    logic             we;
    logic             status_we;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             ovf_set;
    status_t          status;
    logic             unused_addr;

    assign off         = Address[3:2];
    assign unused_addr = ^Address[1:0];
    assign Hit         = (Address[31:4] == BASE_ADDR[31:4]);
    assign we          = MemWrite && Hit;
    assign status_we   = we && (off == OFF_STATUS);
    assign fifo_push   = we && (off == OFF_TX_DATA);
    assign fifo_pop    = tx_valid && tx_ready;
    assign ovf_set     = fifo_push && fifo_full && !fifo_pop;

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (WriteData),
        .dout  (tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign tx_valid = !fifo_empty;
    assign PortOut  = port_out_q;

    // Sticky bits: a set event in the same cycle as W1C keeps the bit at 1.
    always_comb begin
        port_out_d = port_out_q;
        if (we && (off == OFF_PORT_OUT)) begin
            port_out_d = WriteData;
        end
        ovf_d   = ovf_set || (ovf_q && !(status_we && WriteData[ST_OVF]));
        inchg_d = (sync_q != prev_q) || (inchg_q && !(status_we && WriteData[ST_INCHG]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= '0;
            s1_q       <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            ovf_q      <= 1'b0;
            inchg_q    <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            s1_q       <= PortIn;
            sync_q     <= s1_q;
            prev_q     <= sync_q;
            ovf_q      <= ovf_d;
            inchg_q    <= inchg_d;
        end
    end

    always_comb begin
        status            = '0;
        status.empty      = fifo_empty;
        status.full       = fifo_full;
        status.count      = ST_COUNT_W'(fifo_count);
        status.overflow   = ovf_q;
        status.in_changed = inchg_q;
    end

    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (off)
                OFF_PORT_OUT: ReadData = port_out_q;
                OFF_PORT_IN:  ReadData = {24'b0, sync_q};
                OFF_TX_DATA:  ReadData = '0;
                OFF_STATUS:   ReadData = pack_status(status);
                default:      ReadData = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_io_bus_responder : directed + randomized checks against a queue-based model
// Revision            : 1.0
// ============================================================================
module tb_io_bus_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    io_bus_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: FIFO as a queue, PortIn as a history of sampled values.
    logic [31:0] mq[$];
    logic [31:0] m_port_out;
    logic        m_ovf;
    logic        m_inchg;
    logic [7:0]  m_hist [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return (a >> 4) == (BASE >> 4);
    endfunction

    function automatic logic [1:0] m_off(input logic [31:0] a);
        return 2'((a >> 2) & 32'd3);
    endfunction

    function automatic logic [31:0] m_status();
        int n;
        n = mq.size();
        return 32'(n == 0) | (32'(n == DEPTH) << 1) | (32'(n) << 2)
             | (32'(m_ovf) << 7) | (32'(m_inchg) << 8);
    endfunction

    function automatic logic [31:0] m_read();
        if (!(MemRead && m_hit(Address))) return 32'h0;
        case (m_off(Address))
            2'd0:    return m_port_out;
            2'd1:    return {24'b0, m_hist[1]};
            2'd2:    return 32'h0;
            default: return m_status();
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_port_out = '0;
        m_ovf      = 1'b0;
        m_inchg    = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
    endtask

    task automatic model_edge();
        logic we, push, pop, full, chg, clr_o, clr_i;
        logic [1:0] off;
        if (!reset) begin
            model_reset();
        end else begin
            off   = m_off(Address);
            we    = MemWrite && m_hit(Address);
            push  = we && off == 2'd2;
            pop   = (mq.size() > 0) && tx_ready;
            full  = mq.size() == DEPTH;
            chg   = m_hist[1] != m_hist[2];
            clr_o = we && off == 2'd3 && WriteData[7];
            clr_i = we && off == 2'd3 && WriteData[8];
            m_ovf   = (push && full && !pop) || (m_ovf && !clr_o);
            m_inchg = chg || (m_inchg && !clr_i);
            if (pop) void'(mq.pop_front());
            if (push && (!full || pop)) mq.push_back(WriteData);
            if (we && off == 2'd0) m_port_out = WriteData;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = PortIn;
        end
    endtask

    task automatic compare();
        check("hit", 32'(Hit), 32'(m_hit(Address)));
        check("readdata", ReadData, m_read());
        check("portout", PortOut, m_port_out);
        check("txvalid", 32'(tx_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check("txdata", tx_data, mq[0]);
    endtask

    task automatic settle();
        #2;
        compare();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        edge_step();
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = w;
        MemRead   = r;
        Address   = a;
        WriteData = d;
    endtask

    logic [31:0] vals [5];
    logic [31:0] exp4 [4];

    initial begin
        reset    = 1'b0;
        tx_ready = 1'b0;
        PortIn   = 8'h00;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        @(negedge clk);
        cyc();
        cyc();
        reset = 1'b1;

        // Reset state
        drive(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        settle();
        check("rst_status", ReadData, 32'h001);
        check("rst_portout", PortOut, 32'h0);
        check("rst_txvalid", 32'(tx_valid), 32'h0);
        edge_step();

        // PORT_OUT write, out-of-window read
        drive(1'b1, 1'b0, BASE, 32'hDEADBEEF);
        cyc();
        drive(1'b0, 1'b1, 32'h2000_0000, 32'h0);
        settle();
        check("portout_wr", PortOut, 32'hDEADBEEF);
        check("miss_hit", 32'(Hit), 32'h0);
        check("miss_rdata", ReadData, 32'h0);
        edge_step();

        // Overfill, then drain
        vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, BASE + 32'h8, vals[i]);
            cyc();
        end
        drive(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        settle();
        check("ovf_status", ReadData, 32'h092);
        edge_step();
        drive(1'b0, 1'b0, BASE, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain_data", tx_data, vals[i]);
            edge_step();
        end
        settle();
        check("drain_empty", 32'(tx_valid), 32'h0);
        edge_step();
        drive(1'b1, 1'b0, BASE + 32'hC, 32'h80);
        cyc();
        drive(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        settle();
        check("w1c_ovf", ReadData, 32'h001);
        edge_step();

        // Push and pop in the same cycle while full
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, BASE + 32'h8, 32'hA1 + 32'(i));
            cyc();
        end
        tx_ready = 1'b1;
        drive(1'b1, 1'b0, BASE + 32'h8, 32'h66);
        settle();
        check("pp_head", tx_data, 32'hA1);
        edge_step();
        tx_ready = 1'b0;
        drive(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        settle();
        check("pp_status", ReadData, 32'h012);
        edge_step();
        tx_ready = 1'b1;
        drive(1'b0, 1'b0, BASE, 32'h0);
        exp4 = '{32'hA2, 32'hA3, 32'hA4, 32'h66};
        for (int i = 0; i < 4; i++) begin
            settle();
            check("pp_drain", tx_data, exp4[i]);
            edge_step();
        end

        // PortIn synchronizer and change detect
        tx_ready = 1'b0;
        PortIn = 8'hA5;
        drive(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        cyc();
        settle();
        check("sync_1edge", ReadData, 32'h0);
        edge_step();
        settle();
        check("sync_2edge", ReadData, 32'hA5);
        Address = BASE + 32'hC;
        #1;
        check("inchg_2edge", ReadData, 32'h001);
        edge_step();
        settle();
        check("inchg_3edge", ReadData, 32'h101);
        edge_step();
        PortIn = 8'h5A;
        drive(1'b0, 1'b0, BASE, 32'h0);
        cyc();
        cyc();
        drive(1'b1, 1'b0, BASE + 32'hC, 32'h100);
        cyc();
        drive(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        settle();
        check("inchg_set_wins", ReadData, 32'h101);
        edge_step();
        drive(1'b1, 1'b0, BASE + 32'hC, 32'h100);
        cyc();
        drive(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        settle();
        check("inchg_clear", ReadData, 32'h001);
        edge_step();

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, BASE + 32'h8, 32'hC0 + 32'(i));
            cyc();
        end
        drive(1'b0, 1'b0, BASE, 32'h0);
        settle();
        check("pre_rst_valid", 32'(tx_valid), 32'h1);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", 32'(tx_valid), 32'h0);
        compare();
        edge_step();
        reset = 1'b1;
        drive(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        settle();
        check("post_rst_status", ReadData, 32'h001);
        edge_step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            if ($urandom_range(4, 0) != 0)
                a = BASE + 32'($urandom_range(15, 0));
            else
                a = $urandom();
            drive($urandom_range(2, 0) == 0, $urandom_range(1, 0) == 1, a,
                  ($urandom_range(3, 0) == 0) ? 32'($urandom_range(511, 0)) : $urandom());
            tx_ready = (n % 100 < 50) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
            if ($urandom_range(7, 0) == 0) PortIn = 8'($urandom());
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped I/O responder sitting on the processor's data-memory bus, in parallel with the data RAM. It decodes a 16-byte window and provides a PortOut register, a synchronized PortIn register with change detection, and a transmit FIFO that drains to an external valid/ready consumer. Reads are combinational, matching the single-cycle core. Writes commit on the rising clock edge.

## Interface
- BASE_ADDR, 32'h1000_0000: window base, 16-byte aligned.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, 2..16.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data.
- MemWrite  input  1  store strobe, sampled at the clk edge.
- MemRead  input  1  load strobe.
- ReadData  output  32  load data; combinational.
- Hit  output  1  Address[31:4] == BASE_ADDR[31:4]; combinational; selects this block over RAM in the load mux.
- PortIn  input  8  asynchronous external input.
- PortOut  output  32  PORT_OUT register.
- tx_data  output  32  FIFO head.
- tx_valid  output  1  FIFO not empty.
- tx_ready  input  1  consumer accepts the head when tx_valid & tx_ready at a clk edge.

## Operation
- Register map, as offsets in Address[3:2]; Address[1:0] ignored:
  - 0x0 PORT_OUT: read/write.
  - 0x4 PORT_IN: read-only, {24'b0, sync_in}.
  - 0x8 TX_DATA: write-only; a write pushes WriteData; reads return 0.
  - 0xC STATUS: bit0 empty, bit1 full, bits[6:2] count, bit7 overflow (sticky, write 1 to clear), bit8 in_changed (sticky, write 1 to clear); other bits read 0; writes to other bits ignored.
- Write enable: MemWrite & Hit.
- Writes to read-only registers are ignored.
- ReadData = selected register when MemRead & Hit; otherwise 0.
- Reads have no side effects.
- PortIn synchronizer:
  - two flops: s1 <= PortIn, sync_in <= s1.
  - prev_in <= sync_in.
  - in_changed is set when sync_in != prev_in.
- FIFO:
  - circular buffer with read/write pointers and a count register (count width clog2(FIFO_DEPTH)+1).
  - push = TX_DATA write; pop = tx_valid & tx_ready.
  - Push while full without a simultaneous pop: data dropped, overflow set, no other state changes.
  - Push and pop in the same cycle: both occur; count unchanged; this holds even when full.
  - Pop while empty: impossible, since tx_valid = 0.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky bits: a set event in the same cycle as a W1C write wins; the bit stays 1.
- Reset (async assert, any time including mid-transfer): PortOut=0, FIFO empty (pointers and count 0), tx_valid=0, s1/sync_in/prev_in=0, overflow=0, in_changed=0.
  - STATUS reads 0x001 after reset.
  - FIFO storage contents need not be reset.

## Timing
- Loads: zero-cycle latency; ReadData is valid in the same cycle as Address/MemRead.
- Stores: take effect at the clk edge where MemWrite & Hit; the new value is visible to a load in the next cycle.
- Push to an empty FIFO: tx_valid=1 and tx_data valid in the cycle after the push edge; no bypass.
- Pop: the next entry appears the cycle after the accepting edge.
- tx_data is held stable while tx_valid & !tx_ready.
- PortIn change:
  - sync_in updates 2 edges after the input settles.
  - in_changed rises 1 edge later (3 edges total).
- Throughput: one push and one pop per cycle.

## Structure
- Shared package io_bus_pkg holds:
  - offsets OFF_PORT_OUT=2'd0, OFF_PORT_IN=2'd1, OFF_TX_DATA=2'd2, OFF_STATUS=2'd3;
  - STATUS bit indices ST_EMPTY=0, ST_FULL=1, ST_COUNT_LSB=2, ST_OVF=7, ST_INCHG=8;
  - default BASE_ADDR.
- Sub-module io_tx_fifo (parameter DEPTH, WIDTH=32): push, pop, din, dout, empty, full, count.
- Decode, registers, synchronizer and the read mux stay in io_bus_responder.

## Test plan
- Reset then read STATUS (Address 0x1000_000C, MemRead=1) -> ReadData=0x001, PortOut=0, tx_valid=0.
- Write 0xDEADBEEF to 0x1000_0000 -> PortOut=0xDEADBEEF from the next cycle. Read 0x2000_0000 -> Hit=0, ReadData=0.
- With tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> STATUS=0x092 (full, count 4, overflow). Raise tx_ready -> tx_data sequence 0x11,0x22,0x33,0x44, then tx_valid=0. Write 0x80 to STATUS -> STATUS=0x001.
- With the FIFO full and tx_ready=1, push 0x66 in the same cycle as a pop -> count stays 4; 0x66 drains last; overflow stays 0.
- PortIn 0x00 -> 0xA5 -> PORT_IN reads 0xA5 after 2 edges and STATUS bit8=1 after 3 edges. W1C of bit8 in the same cycle as another PortIn change -> bit8 stays 1.
- Assert reset with 3 entries queued and tx_valid=1 -> tx_valid=0 immediately (asynchronous); STATUS=0x001 after release.
